bus_demux_5ch: RTL

Write-side counterpart of the 5-channel Bus_1 source multiplexer in the RISC-SPM datapath. It takes a word from Bus_2 and a 3-bit destination select, and commits the word into one of five storage registers: R0, R1, R2, R3 or PC. It owns those five registers and drives their outputs back to the Bus_1 multiplexer inputs. It adds a one-entry write buffer with a valid/ready handshake, a controller stall input, a PC incrementer and a sticky illegal-select flag.

---
 rtl/risc_spm_pkg.sv | 22 ++
 rtl/pc_counter.sv | 29 ++
 rtl/bus_demux_5ch.sv | 110 +++++++++++
 3 files changed

// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC-SPM datapath: destination select encodings,
// write-buffer state and the default data word width.
package risc_spm_pkg;

   localparam int WS_DEFAULT = 8;

   localparam logic [2:0] SEL_R0 = 3'd0;
   localparam logic [2:0] SEL_R1 = 3'd1;
   localparam logic [2:0] SEL_R2 = 3'd2;
   localparam logic [2:0] SEL_R3 = 3'd3;
   localparam logic [2:0] SEL_PC = 3'd4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   function automatic logic sel_is_legal(input logic [2:0] sel);
      return sel <= SEL_PC;
   endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter storage: synchronous load and +1 increment, load taking
// priority so a bus write to PC always lands intact.
module pc_counter
   import risc_spm_pkg::*;
#(
   parameter int ws = WS_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          inc,
   input  logic [ws-1:0] d,
   output logic [ws-1:0] q
);

   localparam logic [ws-1:0] ONE = {{(ws-1){1'b0}}, 1'b1};

   // NOTE: sequential state uses non-blocking assignments only, so every
   // always_ff reads the pre-edge value of every register.
   always_ff @(posedge clk) begin
      if (!rst)
         q <= '0;
      else if (load)
         q <= d;
      else if (inc)
         q <= q + ONE;   // wraps modulo 2^ws
   end

endmodule

// File: rtl/bus_demux_5ch.sv
// Bus_2 write-side demultiplexer: one-entry stall buffer in front of the
// R0..R3 and PC registers, with a sticky illegal-select flag.
module bus_demux_5ch
   import risc_spm_pkg::*;
#(
   parameter int ws = WS_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [ws-1:0] wr_data,
   input  logic [2:0]    wr_sel,
   input  logic          hold,
   input  logic          inc_pc,
   input  logic          err_clr,
   output logic [ws-1:0] r0_out,
   output logic [ws-1:0] r1_out,
   output logic [ws-1:0] r2_out,
   output logic [ws-1:0] r3_out,
   output logic [ws-1:0] pc_out,
   output logic          sel_err
);

   buf_state_t    state, next_state;
   logic [ws-1:0] buf_data;
   logic [2:0]    buf_sel;
   logic          buf_load;
   logic          commit;
   logic [ws-1:0] commit_data;
   logic [2:0]    commit_sel;

   assign wr_ready = (state == EMPTY);

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a value held and infer a latch.
   always_comb begin
      next_state  = state;
      buf_load    = 1'b0;
      commit      = 1'b0;
      commit_data = wr_data;
      commit_sel  = wr_sel;
      case (state)
         EMPTY: begin
            if (wr_valid) begin
               if (hold) begin
                  buf_load   = 1'b1;
                  next_state = FULL;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         FULL: begin
            if (!hold) begin
               commit      = 1'b1;
               commit_data = buf_data;
               commit_sel  = buf_sel;
               next_state  = EMPTY;
            end
         end
         default: next_state = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= EMPTY;
         r0_out  <= '0;
         r1_out  <= '0;
         r2_out  <= '0;
         r3_out  <= '0;
         sel_err <= 1'b0;
      end else begin
         state <= next_state;
         if (commit) begin
            case (commit_sel)
               SEL_R0:  r0_out <= commit_data;
               SEL_R1:  r1_out <= commit_data;
               SEL_R2:  r2_out <= commit_data;
               SEL_R3:  r3_out <= commit_data;
               default: ;
            endcase
         end
         if (commit && !sel_is_legal(commit_sel))
            sel_err <= 1'b1;   // a new error outranks a same-cycle clear
         else if (err_clr)
            sel_err <= 1'b0;
      end
   end

   // NOTE: the buffer payload is deliberately not reset; reset forces EMPTY,
   // and the payload is only ever read while FULL.
   always_ff @(posedge clk) begin
      if (buf_load) begin
         buf_data <= wr_data;
         buf_sel  <= wr_sel;
      end
   end

   pc_counter #(.ws(ws)) u_pc (
      .clk  (clk),
      .rst  (rst),
      .load (commit && (commit_sel == SEL_PC)),
      .inc  (inc_pc && !hold),
      .d    (commit_data),
      .q    (pc_out)
   );

endmodule
